// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci/Galois LFSR pseudo-random generator.
// Emits STEP_BITS bits per word over a valid/ready handshake, blocks the all-zero lock-up and flags sequence wrap.
module lfsr_prng #(
    parameter int                WIDTH        = 16,
    parameter logic [WIDTH-1:0]  TAPS         = 16'hB400,
    parameter int                STEP_BITS    = 1,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     seed,
    input  logic                 mode,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [STEP_BITS-1:0] out_word,
    output logic [WIDTH-1:0]     state,
    output logic                 seed_err,
    output logic                 seq_wrap
);

    // Galois form shifts toward the MSB, so it uses the reciprocal of the Fibonacci mask.
    localparam logic [WIDTH-1:0] TAPS_G = {TAPS[WIDTH-2:0], 1'b1};

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } phase_t;

    phase_t                 phase;
    phase_t                 phase_next;
    logic                   mode_r;
    logic [WIDTH-1:0]       seed_r;
    logic [WIDTH-1:0]       seed_sel;
    logic [WIDTH-1:0]       load_state;
    logic [WIDTH-1:0]       run_state;
    logic [STEP_BITS-1:0]   load_bits;
    logic [STEP_BITS-1:0]   run_bits;
    logic                   accept;

    // Unrolled STEP_BITS single steps; the first produced bit ends up in the MSB.
    function automatic logic [STEP_BITS+WIDTH-1:0] run_steps(
        input logic [WIDTH-1:0] s_in,
        input logic             galois
    );
        logic [WIDTH-1:0]     s;
        logic [STEP_BITS-1:0] b;
        logic                 fb;
        s = s_in;
        b = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (galois) begin
                fb = s[WIDTH-1];
                s  = {s[WIDTH-2:0], 1'b0} ^ (fb ? TAPS_G : '0);
            end else begin
                fb = ^(s & TAPS);
                s  = {s[WIDTH-2:0], fb};
            end
            b    = b << 1;
            b[0] = fb;
        end
        return {b, s};
    endfunction

    always_comb begin
        seed_sel                = (seed == '0) ? DEFAULT_SEED : seed;
        {load_bits, load_state} = run_steps(seed_sel, mode);
        {run_bits, run_state}   = run_steps(state, mode_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= ST_IDLE;
        end else begin
            phase <= phase_next;
        end
    end

    // The generator stays idle until the first seed load, then runs until reset.
    always_comb begin
        phase_next = phase;
        if (load) begin
            phase_next = ST_RUN;
        end
    end

    always_comb begin
        out_valid = (phase == ST_RUN);
    end

    assign accept = out_valid & out_ready & ~load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= '0;
            out_word <= '0;
            seed_r   <= '0;
            mode_r   <= 1'b0;
            seed_err <= 1'b0;
            seq_wrap <= 1'b0;
        end else begin
            seed_err <= 1'b0;
            seq_wrap <= 1'b0;
            // A load discards whatever word was on the output, even if it was being accepted.
            if (load) begin
                seed_r   <= seed_sel;
                mode_r   <= mode;
                out_word <= load_bits;
                state    <= load_state;
                seed_err <= (seed == '0);
            end else if (accept) begin
                out_word <= run_bits;
                state    <= run_state;
                seq_wrap <= (run_state == seed_r);
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prng.sv
// Scoreboard bench for lfsr_prng: a 4-bit single-step instance and a 16-bit byte-per-word instance.
// Stimulus pushes expected outputs per cycle; per-instance monitors pop and compare after each clock edge.
module tb_lfsr_prng;

    typedef struct {
        logic        valid;
        logic [15:0] word;
        logic [15:0] state;
        logic        err;
        logic        wrap;
    } exp_t;

    logic        clk;
    logic        rst_a, load_a, mode_a, ready_a;
    logic [3:0]  seed_a;
    logic        valid_a, err_a, wrap_a;
    logic [0:0]  word_a;
    logic [3:0]  state_a;
    logic        rst_b, load_b, mode_b, ready_b;
    logic [15:0] seed_b;
    logic        valid_b, err_b, wrap_b;
    logic [7:0]  word_b;
    logic [15:0] state_b;

    exp_t        qa[$];
    exp_t        qb[$];
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [14:0] t1_seq;
    logic [15:0] m_state [2];
    logic [15:0] m_word  [2];
    logic [15:0] m_seed  [2];
    logic        m_valid [2];
    logic        m_mode  [2];
    int          m_pos   [2];
    bit          gap_en = 0;
    int          cyc_a = 0;
    int          last_wrap = -1;

    lfsr_prng #(.WIDTH(4), .TAPS(4'b1100), .STEP_BITS(1), .DEFAULT_SEED(4'd1)) dut_a (
        .clk(clk), .rst(rst_a), .load(load_a), .seed(seed_a), .mode(mode_a),
        .out_ready(ready_a), .out_valid(valid_a), .out_word(word_a), .state(state_a),
        .seed_err(err_a), .seq_wrap(wrap_a)
    );

    lfsr_prng #(.WIDTH(16), .TAPS(16'hB400), .STEP_BITS(8), .DEFAULT_SEED(16'd1)) dut_b (
        .clk(clk), .rst(rst_b), .load(load_b), .seed(seed_b), .mode(mode_b),
        .out_ready(ready_b), .out_valid(valid_b), .out_word(word_b), .state(state_b),
        .seed_err(err_b), .seq_wrap(wrap_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial reference: returns {produced bit, next state} for one step.
    function automatic logic [16:0] model_step(input int w, input logic [15:0] taps,
                                               input logic galois, input logic [15:0] s);
        logic [15:0] mask, tg, ns;
        logic        b;
        mask = 16'((32'd1 << w) - 1);
        if (galois) begin
            b  = s[w-1];
            tg = ((taps << 1) | 16'd1) & mask;
            ns = ((s << 1) & mask) ^ (b ? tg : 16'd0);
        end else begin
            b  = ^(s & taps);
            ns = ((s << 1) | {15'd0, b}) & mask;
        end
        return {b, ns};
    endfunction

    task automatic model_adv(input int which, input logic [15:0] s_in, input logic galois,
                             output logic [15:0] ns, output logic [15:0] wd);
        int          w, n;
        logic [15:0] taps, s;
        logic [16:0] r;
        w    = (which == 0) ? 4 : 16;
        n    = (which == 0) ? 1 : 8;
        taps = (which == 0) ? 16'h000C : 16'hB400;
        s    = s_in;
        wd   = 16'd0;
        for (int i = 0; i < n; i++) begin
            r  = model_step(w, taps, galois, s);
            wd = (wd << 1) | {15'd0, r[16]};
            s  = r[15:0];
        end
        ns = s;
    endtask

    // Drives one cycle of inputs and queues the outputs expected after the next rising edge.
    task automatic apply_stimulus(input int which, input logic r, input logic ld, input logic [15:0] sd,
                                  input logic md, input logic rdy, input bit use_tbl);
        exp_t        e;
        logic [15:0] ns, wd, s0;
        @(negedge clk);
        if (which == 0) begin
            rst_a = r; load_a = ld; seed_a = sd[3:0]; mode_a = md; ready_a = rdy;
        end else begin
            rst_b = r; load_b = ld; seed_b = sd; mode_b = md; ready_b = rdy;
        end
        e.err  = 1'b0;
        e.wrap = 1'b0;
        if (r) begin
            m_state[which] = 16'd0; m_word[which] = 16'd0; m_seed[which] = 16'd0;
            m_valid[which] = 1'b0;  m_mode[which] = 1'b0;
        end else if (ld) begin
            s0 = (sd == 16'd0) ? 16'd1 : sd;
            e.err = (sd == 16'd0);
            m_seed[which] = s0;
            m_mode[which] = md;
            model_adv(which, s0, md, ns, wd);
            m_word[which]  = wd;
            m_state[which] = ns;
            m_valid[which] = 1'b1;
            m_pos[which]   = 0;
        end else if (m_valid[which] && rdy) begin
            model_adv(which, m_state[which], m_mode[which], ns, wd);
            m_word[which]  = wd;
            e.wrap         = (ns == m_seed[which]);
            m_state[which] = ns;
            m_pos[which]++;
        end
        e.word  = use_tbl ? {15'd0, t1_seq[14 - (m_pos[which] % 15)]} : m_word[which];
        e.state = m_state[which];
        e.valid = m_valid[which];
        if (which == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    initial begin : mon_a
        exp_t ea;
        forever begin
            @(posedge clk);
            #1;
            cyc_a++;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check_output("a_valid", {15'd0, valid_a}, {15'd0, ea.valid});
                check_output("a_word", {15'd0, word_a}, ea.word);
                check_output("a_state", {12'd0, state_a}, ea.state);
                check_output("a_seed_err", {15'd0, err_a}, {15'd0, ea.err});
                check_output("a_seq_wrap", {15'd0, wrap_a}, {15'd0, ea.wrap});
                if (valid_a) check_output("a_state_nonzero", {15'd0, state_a != 4'd0}, 16'd1);
                if (!gap_en) begin
                    last_wrap = -1;
                end else if (wrap_a) begin
                    if (last_wrap >= 0) check_output("a_wrap_gap", 16'(cyc_a - last_wrap), 16'd15);
                    last_wrap = cyc_a;
                end
            end
        end
    end

    initial begin : mon_b
        exp_t eb;
        forever begin
            @(posedge clk);
            #1;
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check_output("b_valid", {15'd0, valid_b}, {15'd0, eb.valid});
                check_output("b_word", {8'd0, word_b}, eb.word);
                check_output("b_state", state_b, eb.state);
                check_output("b_seed_err", {15'd0, err_b}, {15'd0, eb.err});
                check_output("b_seq_wrap", {15'd0, wrap_b}, {15'd0, eb.wrap});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        t1_seq = 15'b001101011110001;
        rst_a = 1'b1; load_a = 1'b0; seed_a = 4'd0; mode_a = 1'b0; ready_a = 1'b0;
        rst_b = 1'b1; load_b = 1'b0; seed_b = 16'd0; mode_b = 1'b0; ready_b = 1'b0;

        // Reset state, then out_ready is ignored before any load.
        repeat (2) apply_stimulus(0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) apply_stimulus(0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        // Fibonacci seed 1 against the hand-derived 15-bit sequence, wrap spacing measured.
        gap_en = 1'b1;
        apply_stimulus(0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 1'b1);
        repeat (45) apply_stimulus(0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
        gap_en = 1'b0;

        // Back-pressure freezes word and state, then resumes without skipping.
        repeat (5) apply_stimulus(0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
        repeat (10) apply_stimulus(0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);

        // Zero seed falls back to the default; mode toggles outside a load are ignored.
        apply_stimulus(0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1);
        repeat (16) apply_stimulus(0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1);

        // Mid-stream reset clears outputs at once; load wins over a simultaneous accept.
        apply_stimulus(0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        #1;
        check_output("a_async_rst_state", {12'd0, state_a}, 16'd0);
        check_output("a_async_rst_valid", {15'd0, valid_a}, 16'd0);
        apply_stimulus(0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(0, 1'b0, 1'b1, 16'h000B, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) apply_stimulus(0, 1'b0, 1'b0, 16'd0, 1'b0, (i % 3) != 2, 1'b0);

        // Byte-wide words from the 16-bit generator in both forms.
        repeat (2) apply_stimulus(1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1, 1'b0, 1'b1, 16'hACE1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) apply_stimulus(1, 1'b0, 1'b0, 16'd0, 1'b0, (i % 4) != 3, 1'b0);
        apply_stimulus(1, 1'b0, 1'b1, 16'hACE1, 1'b1, 1'b0, 1'b0);
        repeat (20) apply_stimulus(1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1, 1'b0, 1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
        repeat (4) apply_stimulus(1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check_output("a_queue_drained", 16'(qa.size()), 16'd0);
        check_output("b_queue_drained", 16'(qb.size()), 16'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
